// File: rtl/parser_pkg.sv
// Shared constants, FSM state type and window-count helper for window_parser.
// Honors WINDOW_PARSER_STRIDE1_EN (stride-1 window emission) in win_per_frame.
package parser_pkg;

    localparam int WIN_N     = 4;
    localparam int WIN_BYTES = WIN_N * WIN_N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int win_per_frame(input int img_w, input int img_h);
`ifdef WINDOW_PARSER_STRIDE1_EN
        return (img_w - 3) * (img_h - 3);
`else
        return ((img_w - 4) / 2 + 1) * ((img_h - 4) / 2 + 1);
`endif
    endfunction

endpackage

// File: rtl/line_buf.sv
// One buffered image row: single-port RAM with registered read-before-write.
// Read data holds while en is low, so pixel gaps do not disturb the column in flight.
module line_buf #(
    parameter int DEPTH = 16,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/window_parser.sv
// Raster pixel stream -> 4x4 windows (stride 2, or stride 1 with WINDOW_PARSER_STRIDE1_EN).
// Three rotating line buffers plus a 3-column shift register build each window.
module window_parser
    import parser_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int DW    = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    iVld,
    input  logic                    iSof,
    input  logic [DW-1:0]           iData,
    output logic                    oVld,
    output logic [WIN_BYTES*DW-1:0] oWin,
    output logic                    oFrameDone,
    output logic                    oErr
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t            state_reg, state_next;
    logic [CW-1:0]     col_reg, col_next, pos_col;
    logic [RW-1:0]     row_reg, row_next, pos_row;
    logic [1:0]        ptr_reg, ptr_next;
    logic              accept, stray, emit, phase_ok, last_col, last_pix;

    logic              vld_reg, done_reg, err_reg, take_reg;
    logic [1:0]        rot_reg;
    logic [DW-1:0]     data_reg;
    logic [WIN_BYTES*DW-1:0] hold_reg, win_cur;

    logic [DW-1:0]                      lb_rd [3];
    logic [WIN_N-1:0][DW-1:0]           new_col;
    logic [WIN_N-2:0][WIN_N-1:0][DW-1:0] sr_reg;
    logic [1:0]                         sel0, sel1, sel2;

    // Position of the pixel on this beat; a start-of-frame beat is always (0,0).
    assign pos_col  = iSof ? '0 : col_reg;
    assign pos_row  = iSof ? '0 : row_reg;
    assign accept   = iVld & (iSof | (state_reg == FILL) | (state_reg == RUN));
    assign stray    = iVld & ~accept;
    assign last_col = (pos_col == CW'(IMG_W - 1));
    assign last_pix = last_col & (pos_row == RW'(IMG_H - 1));

`ifdef WINDOW_PARSER_STRIDE1_EN
    assign phase_ok = 1'b1;
`else
    assign phase_ok = pos_row[0] & pos_col[0];
`endif

    assign emit = accept & (pos_row >= RW'(3)) & (pos_col >= CW'(3)) & phase_ok;

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        ptr_next   = ptr_reg;
        if (accept) begin
            col_next = last_col ? '0 : pos_col + 1'b1;
            if (last_col) begin
                row_next = last_pix ? '0 : pos_row + 1'b1;
                ptr_next = (ptr_reg == 2'd2) ? 2'd0 : ptr_reg + 2'd1;
            end else begin
                row_next = pos_row;
            end
        end
        unique case (state_reg)
            IDLE: begin
                if (accept) state_next = FILL;
            end
            FILL: begin
                if (accept) begin
                    if (iSof)                        state_next = FILL;
                    else if (pos_row == RW'(3))      state_next = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (iSof)          state_next = FILL;
                    else if (last_pix) state_next = DONE;
                end
            end
            DONE: begin
                state_next = accept ? FILL : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
            ptr_reg   <= '0;
            vld_reg   <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            take_reg  <= 1'b0;
            rot_reg   <= '0;
            data_reg  <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            ptr_reg   <= ptr_next;
            vld_reg   <= emit;
            done_reg  <= (state_reg == DONE);
            err_reg   <= err_reg | stray;
            take_reg  <= accept;
            if (accept) begin
                rot_reg  <= ptr_reg;
                data_reg <= iData;
            end
            if (vld_reg) begin
                hold_reg <= win_cur;
            end
        end
    end

    // Buffer ptr holds row r-3: its read-before-write returns that row while row r overwrites it.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lb
            line_buf #(
                .DEPTH (IMG_W),
                .DW    (DW)
            ) u_lb (
                .clk   (clk),
                .en    (accept),
                .we    (ptr_reg == 2'(gi)),
                .addr  (pos_col),
                .wdata (iData),
                .rdata (lb_rd[gi])
            );
        end
    endgenerate

    always_comb begin
        sel0 = 2'd0;
        sel1 = 2'd1;
        sel2 = 2'd2;
        case (rot_reg)
            2'd1: begin sel0 = 2'd1; sel1 = 2'd2; sel2 = 2'd0; end
            2'd2: begin sel0 = 2'd2; sel1 = 2'd0; sel2 = 2'd1; end
            default: begin sel0 = 2'd0; sel1 = 2'd1; sel2 = 2'd2; end
        endcase
    end

    assign new_col[0] = lb_rd[sel0];
    assign new_col[1] = lb_rd[sel1];
    assign new_col[2] = lb_rd[sel2];
    assign new_col[3] = data_reg;

    // The column read on a beat lands the cycle after; shift it in on the following edge.
    always_ff @(posedge clk) begin
        if (take_reg) begin
            sr_reg <= {new_col, sr_reg[WIN_N-2:1]};
        end
    end

    generate
        for (genvar gi = 0; gi < WIN_N; gi++) begin : g_row
            for (genvar gj = 0; gj < WIN_N; gj++) begin : g_col
                if (gj == WIN_N - 1) begin : g_new
                    assign win_cur[DW*(gi*WIN_N+gj) +: DW] = new_col[gi];
                end else begin : g_old
                    assign win_cur[DW*(gi*WIN_N+gj) +: DW] = sr_reg[gj][gi];
                end
            end
        end
    endgenerate

    assign oVld       = vld_reg;
    assign oWin       = vld_reg ? win_cur : hold_reg;
    assign oFrameDone = done_reg;
    assign oErr       = err_reg;

endmodule

// File: tb/tb_window_parser.sv
// Directed bench for window_parser: 8x8 and 16x16 instances driven with ramp frames.
// Expected windows come from a raster model of the emit rule (stride set by WINDOW_PARSER_STRIDE1_EN).
module tb_window_parser;

`ifdef WINDOW_PARSER_STRIDE1_EN
    localparam int STRIDE = 1;
    localparam int EXP8   = 25;
    localparam int EXP16  = 169;
    localparam int SEC_B0  = 1;
    localparam int SEC_B15 = 28;
`else
    localparam int STRIDE = 2;
    localparam int EXP8   = 9;
    localparam int EXP16  = 49;
    localparam int SEC_B0  = 2;
    localparam int SEC_B15 = 29;
`endif

    logic         clk = 1'b0;
    logic         rstn8 = 1'b0, rstn16 = 1'b0;
    logic         vld8 = 1'b0, sof8 = 1'b0, vld16 = 1'b0, sof16 = 1'b0;
    logic [7:0]   data8 = '0, data16 = '0;
    logic         v8, fd8, e8, v16, fd16, e16;
    logic [127:0] w8, w16;

    always #5 clk = ~clk;

    window_parser #(.IMG_W(8), .IMG_H(8), .DW(8)) dut8 (
        .clk(clk), .rstn(rstn8), .iVld(vld8), .iSof(sof8), .iData(data8),
        .oVld(v8), .oWin(w8), .oFrameDone(fd8), .oErr(e8)
    );

    window_parser #(.IMG_W(16), .IMG_H(16), .DW(8)) dut16 (
        .clk(clk), .rstn(rstn16), .iVld(vld16), .iSof(sof16), .iData(data16),
        .oVld(v16), .oWin(w16), .oFrameDone(fd16), .oErr(e16)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitors capture every window and frame-done pulse on the falling edge.
    int           cyc = 0;
    logic [127:0] got8_q[$], got16_q[$], exp_q[$];
    int           vcyc8_q[$];
    int           fd8_cnt = 0, fd16_cnt = 0, fd8_cyc = -1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (v8) begin
            got8_q.push_back(w8);
            vcyc8_q.push_back(cyc);
        end
        if (fd8) begin
            fd8_cnt++;
            fd8_cyc = cyc;
        end
        if (v16) got16_q.push_back(w16);
        if (fd16) fd16_cnt++;
    end

    function automatic logic [7:0] pix(input int w, input int r, input int c);
        int v;
        v = r * w + c;
        return v[7:0];
    endfunction

    task automatic gen_exp(input int w, input int h, input int limit);
        logic [127:0] win;
        for (int r = 3; r < h; r++) begin
            for (int c = 3; c < w; c++) begin
                if ((r * w + c) < limit && ((r - 3) % STRIDE) == 0 && ((c - 3) % STRIDE) == 0) begin
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++)
                            win[8*(i*4+j) +: 8] = pix(w, r - 3 + i, c - 3 + j);
                    exp_q.push_back(win);
                end
            end
        end
    endtask

    task automatic beat8(input logic s, input logic [7:0] d);
        @(negedge clk);
        vld8 = 1'b1; sof8 = s; data8 = d;
    endtask

    task automatic idle8(input int n);
        repeat (n) begin
            @(negedge clk);
            vld8 = 1'b0; sof8 = 1'b0;
        end
    endtask

    task automatic beat16(input logic s, input logic [7:0] d);
        @(negedge clk);
        vld16 = 1'b1; sof16 = s; data16 = d;
    endtask

    task automatic idle16(input int n);
        repeat (n) begin
            @(negedge clk);
            vld16 = 1'b0; sof16 = 1'b0;
        end
    endtask

    // gap: 0 = continuous; 1 = alternate idle cycles, then random idle runs.
    task automatic frame8(input int gap, input int n_pix, output int c33);
        c33 = -1;
        for (int idx = 0; idx < n_pix; idx++) begin
            if (gap != 0) begin
                if (idx < 32) idle8(1);
                else idle8(int'($urandom_range(0, 3)));
            end
            beat8(idx == 0, pix(8, idx / 8, idx % 8));
            if (idx == 27) c33 = cyc + 1;
        end
    endtask

    task automatic frame16(input int n_pix);
        for (int idx = 0; idx < n_pix; idx++)
            beat16(idx == 0, pix(16, idx / 16, idx % 16));
    endtask

    task automatic cmp8(input string tag);
        check({tag, "_count"}, 128'(got8_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < got8_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_win%0d", tag, i), got8_q[i], exp_q[i]);
    endtask

    task automatic cmp16(input string tag);
        check({tag, "_count"}, 128'(got16_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < got16_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_win%0d", tag, i), got16_q[i], exp_q[i]);
    endtask

    task automatic clear8();
        got8_q.delete();
        vcyc8_q.delete();
        exp_q.delete();
        fd8_cnt = 0;
        fd8_cyc = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c33;
        repeat (3) @(negedge clk);
        check("rst_vld8", 128'(v8), 128'(0));
        check("rst_win8", w8, 128'(0));
        check("rst_fd8", 128'(fd8), 128'(0));
        check("rst_err8", 128'(e8), 128'(0));
        check("rst_vld16", 128'(v16), 128'(0));
        rstn8 = 1'b1;
        rstn16 = 1'b1;

        // Stray beats before any start of frame.
        idle8(2);
        check("err_before_stray", 128'(e8), 128'(0));
        repeat (3) beat8(1'b0, 8'h55);
        idle8(3);
        check("err_after_stray", 128'(e8), 128'(1));
        check("stray_no_vld", 128'(got8_q.size()), 128'(0));
        $display("[TB] stray beats: oErr=%0b windows=%0d", e8, got8_q.size());

        // Continuous 8x8 ramp frame.
        clear8();
        frame8(0, 64, c33);
        idle8(4);
        gen_exp(8, 8, 64);
        check("cont_count_spec", 128'(got8_q.size()), 128'(EXP8));
        cmp8("cont");
        if (vcyc8_q.size() > 0) begin
            check("cont_latency", 128'(vcyc8_q[0]), 128'(c33));
            check("cont_first_win", got8_q[0], 128'h1b1a1918_13121110_0b0a0908_03020100);
            check("cont_last_b15", 128'(got8_q[got8_q.size()-1][127:120]), 128'(63));
            check("cont_fd_timing", 128'(fd8_cyc), 128'(vcyc8_q[vcyc8_q.size()-1] + 1));
        end
        if (got8_q.size() > 1) begin
            check("cont_second_b0", 128'(got8_q[1][7:0]), 128'(SEC_B0));
            check("cont_second_b15", 128'(got8_q[1][127:120]), 128'(SEC_B15));
        end
        check("cont_fd_count", 128'(fd8_cnt), 128'(1));
        check("cont_err_sticky", 128'(e8), 128'(1));
        check("cont_win_hold", w8, exp_q[exp_q.size()-1]);
        $display("[TB] continuous frame: windows=%0d frame_done=%0d", got8_q.size(), fd8_cnt);

        // Same frame with valid gaps.
        clear8();
        frame8(1, 64, c33);
        idle8(4);
        gen_exp(8, 8, 64);
        cmp8("gap");
        check("gap_fd_count", 128'(fd8_cnt), 128'(1));
        $display("[TB] gapped frame: windows=%0d frame_done=%0d", got8_q.size(), fd8_cnt);

        // Abort at pixel (5,2) by restarting the frame there.
        clear8();
        frame8(0, 42, c33);
        frame8(0, 64, c33);
        idle8(4);
        gen_exp(8, 8, 42);
        gen_exp(8, 8, 64);
        cmp8("abort");
        check("abort_fd_count", 128'(fd8_cnt), 128'(1));
        $display("[TB] abort + new frame: windows=%0d frame_done=%0d", got8_q.size(), fd8_cnt);

        // 16x16: reset while a window is on the output, then a full frame.
        frame16(7 * 16 + 6);
        @(negedge clk);
        vld16 = 1'b0; sof16 = 1'b0;
        check("pre_rst_vld16", 128'(v16), 128'(1));
        #1 rstn16 = 1'b0;
        #1;
        check("rst_mid_vld16", 128'(v16), 128'(0));
        check("rst_mid_win16", w16, 128'(0));
        check("rst_mid_fd16", 128'(fd16), 128'(0));
        repeat (2) @(negedge clk);
        rstn16 = 1'b1;
        got16_q.delete();
        exp_q.delete();
        fd16_cnt = 0;
        frame16(256);
        idle16(4);
        gen_exp(16, 16, 256);
        check("f16_count_spec", 128'(got16_q.size()), 128'(EXP16));
        cmp16("f16");
        check("f16_fd_count", 128'(fd16_cnt), 128'(1));
        check("f16_err", 128'(e16), 128'(0));
        $display("[TB] 16x16 after reset: windows=%0d frame_done=%0d", got16_q.size(), fd16_cnt);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
